procesador_cfg_master: RTL and testbench

PROCESADOR_CFG_MASTER -- requirements
Module: procesador_cfg_master

---
 rtl/procesador_cfg_master.sv | 110 +++++++++++
 tb/tb_procesador_cfg_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procesador_cfg_master.sv
// Avalon-MM configuration master: writes one value to a slave register, reads it back,
// and retries the write until the readback matches or the retry budget is spent.
module procesador_cfg_master #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned ADDR      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] readback,
  output logic [1:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCheck, StDone, StErr} state_e;

  localparam logic [1:0] SlaveAddr = 2'(ADDR);

  state_e            state_q;
  logic [DATA_W-1:0] val_q;
  logic [31:0]       rd_q;
  logic [3:0]        retry_q;
  logic              match;

  // Full 32-bit compare also requires the bits above DATA_W to read back as zero.
  assign match = (rd_q == 32'(val_q));

  // Outputs are registered alongside the state, so each transition also loads the
  // bus values that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      val_q      <= '0;
      rd_q       <= '0;
      retry_q    <= '0;
      readback   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= 2'd0;
      writedata  <= 32'h0;
    end else begin
      done       <= 1'b0;
      error      <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      address    <= 2'd0;
      writedata  <= 32'h0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            val_q      <= value;
            retry_q    <= '0;
            state_q    <= StWrite;
            busy       <= 1'b1;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= SlaveAddr;
            writedata  <= 32'(value);
          end
        end
        StWrite: begin
          state_q    <= StRead;
          chipselect <= 1'b1;
          address    <= SlaveAddr;
        end
        StRead: begin
          rd_q    <= readdata;
          state_q <= StCheck;
        end
        StCheck: begin
          readback <= rd_q[DATA_W-1:0];
          if (match) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else if (32'(retry_q) < MAX_RETRY) begin
            retry_q    <= retry_q + 4'd1;
            state_q    <= StWrite;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            address    <= SlaveAddr;
            writedata  <= 32'(val_q);
          end else begin
            state_q <= StErr;
            error   <= 1'b1;
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_procesador_cfg_master.sv
// Bench for procesador_cfg_master: slave model, transaction-level output model checked every
// cycle, and directed scenarios with hand-computed latencies and write counts.
module tb_procesador_cfg_master;

  localparam int unsigned MaxRetry = 3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] value;
  logic        busy, done, error, chipselect, write_n;
  logic [15:0] readback;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;

  always #5 clk = ~clk;

  procesador_cfg_master #(
    .DATA_W   (16),
    .MAX_RETRY(MaxRetry),
    .ADDR     (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .readback  (readback),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: mode 0 = 16-bit register at address 0, 1 = stuck at zero, 2 = scripted reads.
  int          mode = 0;
  logic [15:0] slave_reg = 16'h0;
  logic [31:0] seq [4];
  int          seq_n = 1;
  int          rd_cnt = 0;
  int          sidx;
  logic        seq_clr = 1'b0;

  always_comb begin
    sidx = (rd_cnt < seq_n) ? rd_cnt : seq_n - 1;
    case (mode)
      0:       readdata = (address == 2'd0) ? {16'h0, slave_reg} : 32'h0;
      1:       readdata = 32'h0;
      default: readdata = seq[sidx];
    endcase
  end

  always @(posedge clk) begin
    if (chipselect && !write_n && address == 2'd0) slave_reg <= writedata[15:0];
    if (seq_clr) rd_cnt <= 0;
    else if (chipselect && write_n) rd_cnt <= rd_cnt + 1;
  end

  // Model: on an accepted start, the whole expected output trace is laid out in a queue.
  // Entry = {busy, done, error, chipselect, write_n, address, writedata, readback}.
  typedef logic [54:0] exp_t;
  exp_t        exp_q[$];
  logic [15:0] model_rb = 16'h0;
  bit          cur_idle = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] model_resp(input int a, input logic [15:0] v);
    int k;
    case (mode)
      0:       return {16'h0, v};
      1:       return 32'h0;
      default: begin
        k = rd_cnt + a;
        if (k >= seq_n) k = seq_n - 1;
        return seq[k];
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_rb = 16'h0;
    end else if (cur_idle && start) begin
      logic [15:0] rb;
      logic [31:0] r;
      bit ok;
      rb = model_rb;
      ok = 1'b0;
      for (int a = 0; a <= int'(MaxRetry) && !ok; a++) begin
        exp_q.push_back({5'b10010, 2'd0, {16'h0, value}, rb});
        exp_q.push_back({5'b10011, 2'd0, 32'h0, rb});
        exp_q.push_back({5'b10001, 2'd0, 32'h0, rb});
        r  = model_resp(a, value);
        rb = r[15:0];
        ok = (r == {16'h0, value});
      end
      exp_q.push_back({1'b1, ok, !ok, 2'b01, 2'd0, 32'h0, rb});
      model_rb = rb;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cur_idle = (exp_q.size() == 0);
    if (cur_idle) e = {5'b00001, 2'd0, 32'h0, model_rb};
    else          e = exp_q.pop_front();
    if (chk_en)
      check("cycle_outputs",
            {9'h0, busy, done, error, chipselect, write_n, address, writedata, readback},
            {9'h0, e});
  end

  // Transaction monitor, cycles counted relative to t0 (the cycle start is first high).
  int          t0 = 0;
  int          done_at, err_at, n_done, n_err;
  logic [15:0] rb_end;
  int          wr_cyc[$];
  logic [31:0] wr_dat[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cyc - t0;
        rb_end = readback;
      end
      if (error) begin
        n_err++;
        if (err_at < 0) err_at = cyc - t0;
        rb_end = readback;
      end
      if (chipselect && !write_n) begin
        wr_cyc.push_back(cyc - t0);
        wr_dat.push_back(writedata);
      end
    end
  end

  task automatic clear_mon();
    done_at = -1;
    err_at  = -1;
    n_done  = 0;
    n_err   = 0;
    rb_end  = 16'h0;
    wr_cyc.delete();
    wr_dat.delete();
  endtask

  task automatic set_seq(input logic [31:0] r0, input logic [31:0] r1);
    mode   = 2;
    seq[0] = r0;
    seq[1] = r1;
    seq_n  = 2;
    @(posedge clk); #1;
    seq_clr = 1'b1;
    @(posedge clk); #1;
    seq_clr = 1'b0;
  endtask

  task automatic txn(input string name, input logic [15:0] v, input int exp_lat,
                     input bit exp_err, input int exp_writes);
    @(posedge clk); #1;
    clear_mon();
    t0    = cyc;
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60 && done_at < 0 && err_at < 0; i++) @(posedge clk);
    #1;
    if (exp_err) begin
      check({name, "_err_latency"}, 64'(err_at), 64'(exp_lat));
      check({name, "_no_done"}, 64'(n_done), 64'd0);
    end else begin
      check({name, "_done_latency"}, 64'(done_at), 64'(exp_lat));
      check({name, "_no_error"}, 64'(n_err), 64'd0);
    end
    check({name, "_writes"}, 64'(wr_cyc.size()), 64'(exp_writes));
    check({name, "_first_write_cycle"}, 64'(wr_cyc[0]), 64'd1);
    check({name, "_first_writedata"}, 64'(wr_dat[0]), {48'h0, v});
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    value  = 16'h0;
    seq[0] = 32'h0;
    seq[1] = 32'h0;
    seq[2] = 32'h0;
    seq[3] = 32'h0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_outputs",
          {9'h0, busy, done, error, chipselect, write_n, address, writedata, readback},
          {9'h0, 5'b00001, 2'd0, 32'h0, 16'h0});
    reset = 1'b0;

    mode = 0;
    txn("nominal", 16'h00A5, 4, 1'b0, 1);
    check("nominal_readback", 64'(rb_end), 64'h00A5);

    mode = 1;
    txn("stuck", 16'h0010, 13, 1'b1, 4);
    check("stuck_last_write_cycle", 64'(wr_cyc[3]), 64'd10);

    set_seq(32'h0000_0011, 32'h0000_0010);
    txn("transient", 16'h0010, 7, 1'b0, 2);
    check("transient_retry_write_cycle", 64'(wr_cyc[1]), 64'd4);

    set_seq(32'h0001_0010, 32'h0000_0010);
    txn("upper_bits", 16'h0010, 7, 1'b0, 2);
    check("upper_bits_readback", 64'(rb_end), 64'h0010);

    // start held for 10 cycles with a changing value
    mode = 0;
    @(posedge clk); #1;
    clear_mon();
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      value = 16'h0100 + 16'(i);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("held_done_count", 64'(n_done), 64'd2);
    check("held_first_done", 64'(done_at), 64'd4);
    check("held_writes", 64'(wr_cyc.size()), 64'd2);
    check("held_write0", 64'(wr_dat[0]), 64'h0100);
    check("held_write1", 64'(wr_dat[1]), 64'h0105);
    check("held_write1_cycle", 64'(wr_cyc[1]), 64'd6);

    // reset during READ, with start also high in that cycle
    @(posedge clk); #1;
    clear_mon();
    t0    = cyc;
    start = 1'b1;
    value = 16'h0055;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_in_read_cs", 64'(chipselect && write_n), 64'd1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_idle_outputs",
          {9'h0, busy, done, error, chipselect, write_n, address, writedata, readback},
          {9'h0, 5'b00001, 2'd0, 32'h0, 16'h0});
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", 64'(n_done), 64'd0);
    check("rst_no_error", 64'(n_err), 64'd0);
    check("rst_single_write", 64'(wr_cyc.size()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
